// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared constants and types for the AXI4-Lite register bank:
//                response codes, write-channel FSM encoding, default depth.
//  Revision    : 1.0  initial release
// ============================================================================
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NREGS_DEFAULT = 16;

    // Write channel progress: which of AW / W has been seen so far.
    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wstate_e;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_regbank_if.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regbank_if
//  Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels) with
//                master and slave views.
//  Revision    : 1.0  initial release
// ============================================================================
interface axil_regbank_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   AWADDR;
    logic               AWVALID;
    logic               AWREADY;

    logic [WIDTH-1:0]   WDATA;
    logic [WIDTH/8-1:0] WSTRB;
    logic               WVALID;
    logic               WREADY;

    logic [1:0]         BRESP;
    logic               BVALID;
    logic               BREADY;

    logic [WIDTH-1:0]   ARADDR;
    logic               ARVALID;
    logic               ARREADY;

    logic [WIDTH-1:0]   RDATA;
    logic [1:0]         RRESP;
    logic               RVALID;
    logic               RREADY;

    modport master (
        output AWADDR, AWVALID, input  AWREADY,
        output WDATA, WSTRB, WVALID, input  WREADY,
        input  BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input  ARREADY,
        input  RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WVALID, output WREADY,
        output BRESP, BVALID, input  BREADY,
        input  ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input  RREADY
    );

endinterface : axil_regbank_if
`default_nettype wire

// File: rtl/axil_reg_array.sv
`default_nettype none
// ============================================================================
//  Module      : axil_reg_array
//  Description : NREGS x WIDTH register file with one byte-strobed write
//                port and one combinational read port.
//  Revision    : 1.0  initial release
// ============================================================================
module axil_reg_array
    import axil_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = NREGS_DEFAULT
) (
    input  wire logic                     clk_i,
    input  wire logic                     rst_i,
    input  wire logic                     we_i,
    input  wire logic [$clog2(NREGS)-1:0] widx_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic [WIDTH/8-1:0]       wstrb_i,
    input  wire logic [$clog2(NREGS)-1:0] ridx_i,
    output logic      [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] w_merged;

    // Byte-lane merge: enabled lanes take new data, the rest keep old bytes.
    for (genvar b = 0; b < WIDTH/8; b++) begin : g_lane
        assign w_merged[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8]
                                               : regs_q[widx_i][8*b +: 8];
    end

    // Register storage: cleared on reset, merged word written on enable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (we_i) begin
            regs_q[widx_i] <= w_merged;
        end
    end

    // Read port sees the current (pre-write) contents.
    assign rdata_o = regs_q[ridx_i];

endmodule : axil_reg_array
`default_nettype wire

// File: rtl/axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : axil_regbank
//  Description : AXI4-Lite responder exposing NREGS registers at byte
//                offsets 4*i. Independent write FSM and pipelined read path.
//  Revision    : 1.0  initial release
// ============================================================================
module axil_regbank
    import axil_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = NREGS_DEFAULT
) (
    input  wire logic       ACLK,
    input  wire logic       ARESET,
    axil_regbank_if.slave   s_axil
);

    localparam int IDXW = $clog2(NREGS);

    wstate_e            state_q, state_d;
    logic [WIDTH-1:0]   awaddr_q;
    logic [WIDTH-1:0]   wdata_q;
    logic [WIDTH/8-1:0] wstrb_q;
    logic [1:0]         bresp_q;
    logic               rvalid_q;
    logic [WIDTH-1:0]   rdata_q;
    logic [1:0]         rresp_q;

    logic               w_aw_hs, w_w_hs, w_ar_hs;
    logic               w_lat_addr, w_lat_data, w_commit;
    logic [WIDTH-1:0]   w_cmt_addr, w_cmt_data;
    logic [WIDTH/8-1:0] w_cmt_strb;
    logic               w_wr_in_range, w_rd_in_range;
    logic [WIDTH-1:0]   w_arr_rdata;
    logic               w_unused_addr_lsbs;

    // Ready signals: forced low during reset, otherwise state driven.
    assign s_axil.AWREADY = !ARESET && (state_q == W_IDLE || state_q == W_HAVE_DATA);
    assign s_axil.WREADY  = !ARESET && (state_q == W_IDLE || state_q == W_HAVE_ADDR);
    assign s_axil.ARREADY = !ARESET && (!rvalid_q || s_axil.RREADY);
    assign s_axil.BVALID  = (state_q == W_RESP);
    assign s_axil.BRESP   = bresp_q;
    assign s_axil.RVALID  = rvalid_q;
    assign s_axil.RDATA   = rdata_q;
    assign s_axil.RRESP   = rresp_q;

    assign w_aw_hs = s_axil.AWVALID && s_axil.AWREADY;
    assign w_w_hs  = s_axil.WVALID  && s_axil.WREADY;
    assign w_ar_hs = s_axil.ARVALID && s_axil.ARREADY;

    // Any set bit above the register index field is out of range.
    assign w_wr_in_range = (w_cmt_addr[WIDTH-1:IDXW+2] == '0);
    assign w_rd_in_range = (s_axil.ARADDR[WIDTH-1:IDXW+2] == '0);
    assign w_unused_addr_lsbs = ^{w_cmt_addr[1:0], s_axil.ARADDR[1:0]};

    // Write FSM state register.
    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= W_IDLE;
        else        state_q <= state_d;
    end

    // Write FSM next state; the completing handshake commits using whichever
    // half is live on the bus and whichever half was latched earlier.
    always_comb begin
        state_d    = state_q;
        w_lat_addr = 1'b0;
        w_lat_data = 1'b0;
        w_commit   = 1'b0;
        w_cmt_addr = awaddr_q;
        w_cmt_data = wdata_q;
        w_cmt_strb = wstrb_q;
        case (state_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    state_d    = W_RESP;
                    w_commit   = 1'b1;
                    w_cmt_addr = s_axil.AWADDR;
                    w_cmt_data = s_axil.WDATA;
                    w_cmt_strb = s_axil.WSTRB;
                end else if (w_aw_hs) begin
                    state_d    = W_HAVE_ADDR;
                    w_lat_addr = 1'b1;
                end else if (w_w_hs) begin
                    state_d    = W_HAVE_DATA;
                    w_lat_data = 1'b1;
                end
            end
            W_HAVE_ADDR: begin
                if (w_w_hs) begin
                    state_d    = W_RESP;
                    w_commit   = 1'b1;
                    w_cmt_data = s_axil.WDATA;
                    w_cmt_strb = s_axil.WSTRB;
                end
            end
            W_HAVE_DATA: begin
                if (w_aw_hs) begin
                    state_d    = W_RESP;
                    w_commit   = 1'b1;
                    w_cmt_addr = s_axil.AWADDR;
                end
            end
            W_RESP: begin
                if (s_axil.BREADY) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Hold the first-arriving half of a split write.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (w_lat_addr) awaddr_q <= s_axil.AWADDR;
            if (w_lat_data) begin
                wdata_q <= s_axil.WDATA;
                wstrb_q <= s_axil.WSTRB;
            end
        end
    end

    // Write response code captured on the committing edge.
    always_ff @(posedge ACLK) begin
        if (ARESET)        bresp_q <= RESP_OKAY;
        else if (w_commit) bresp_q <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end

    // Read channel: new beat on AR handshake, otherwise drain on R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= w_rd_in_range ? w_arr_rdata : '0;
            rresp_q  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axil.RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    axil_reg_array #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_reg_array (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .we_i    (w_commit && w_wr_in_range),
        .widx_i  (w_cmt_addr[IDXW+1:2]),
        .wdata_i (w_cmt_data),
        .wstrb_i (w_cmt_strb),
        .ridx_i  (s_axil.ARADDR[IDXW+1:2]),
        .rdata_o (w_arr_rdata)
    );

endmodule : axil_regbank
`default_nettype wire

// File: tb/tb_axil_regbank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_regbank
//  Description : Directed self-checking bench for axil_regbank (NREGS=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axil_regbank;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    axil_regbank_if #(.WIDTH(32)) bus ();

    axil_regbank #(
        .WIDTH (32),
        .NREGS (16)
    ) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .s_axil (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a pending B response, then complete the handshake.
    task automatic b_done(input logic [1:0] exp_resp);
        check_eq("bvalid", {31'b0, bus.BVALID}, 32'd1);
        check_eq("bresp", {30'b0, bus.BRESP}, {30'b0, exp_resp});
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check_eq("bvalid_clr", {31'b0, bus.BVALID}, 32'd0);
    endtask

    // AW and W presented together.
    task automatic wr_same(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
        bus.AWADDR = addr; bus.AWVALID = 1'b1;
        bus.WDATA  = data; bus.WSTRB   = strb; bus.WVALID = 1'b1;
        #1;
        check_eq("wr_awready", {31'b0, bus.AWREADY}, 32'd1);
        check_eq("wr_wready",  {31'b0, bus.WREADY},  32'd1);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        b_done(exp_resp);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bus.ARADDR = addr; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        #1;
        check_eq("rd_arready", {31'b0, bus.ARREADY}, 32'd1);
        tick();
        bus.ARVALID = 1'b0;
        check_eq($sformatf("rd_rvalid@%0h", addr), {31'b0, bus.RVALID}, 32'd1);
        check_eq($sformatf("rd_rdata@%0h", addr), bus.RDATA, exp_data);
        check_eq($sformatf("rd_rresp@%0h", addr), {30'b0, bus.RRESP}, {30'b0, exp_resp});
        tick();
        bus.RREADY = 1'b0;
        check_eq("rd_rvalid_clr", {31'b0, bus.RVALID}, 32'd0);
    endtask

    initial begin
        bus.AWADDR = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WSTRB   = '0; bus.WVALID = 1'b0;
        bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

        // Reset values and ready gating
        repeat (3) tick();
        check_eq("rst_awready", {31'b0, bus.AWREADY}, 32'd0);
        check_eq("rst_wready",  {31'b0, bus.WREADY},  32'd0);
        check_eq("rst_arready", {31'b0, bus.ARREADY}, 32'd0);
        check_eq("rst_bvalid",  {31'b0, bus.BVALID},  32'd0);
        check_eq("rst_rvalid",  {31'b0, bus.RVALID},  32'd0);
        check_eq("rst_rdata",   bus.RDATA, 32'd0);
        check_eq("rst_bresp",   {30'b0, bus.BRESP}, 32'd0);
        check_eq("rst_rresp",   {30'b0, bus.RRESP}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rel_awready", {31'b0, bus.AWREADY}, 32'd1);
        check_eq("rel_wready",  {31'b0, bus.WREADY},  32'd1);
        check_eq("rel_arready", {31'b0, bus.ARREADY}, 32'd1);

        // Same-cycle AW+W, full strobe
        wr_same(32'h04, 32'hDEADBEEF, 4'hF, OKAY);
        rd(32'h04, 32'hDEADBEEF, OKAY);

        // AW three cycles ahead of W, low half-word strobe
        bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("ha_wready",  {31'b0, bus.WREADY},  32'd1);
            check_eq("ha_awready", {31'b0, bus.AWREADY}, 32'd0);
            check_eq("ha_bvalid",  {31'b0, bus.BVALID},  32'd0);
            tick();
        end
        bus.WDATA = 32'h12345678; bus.WSTRB = 4'h3; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        b_done(OKAY);
        rd(32'h08, 32'h00005678, OKAY);

        // W ahead of AW, out-of-range address
        bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.WVALID = 1'b0;
        check_eq("hd_awready", {31'b0, bus.AWREADY}, 32'd1);
        check_eq("hd_wready",  {31'b0, bus.WREADY},  32'd0);
        bus.AWADDR = 32'h40; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        b_done(SLVERR);
        rd(32'h40, 32'h0, SLVERR);
        rd(32'h00, 32'h0, OKAY);
        rd(32'h04, 32'hDEADBEEF, OKAY);
        rd(32'h08, 32'h00005678, OKAY);

        // Strobe merge, zero strobe, ignored address LSBs
        wr_same(32'h0C, 32'hA5A5A5A5, 4'hF, OKAY);
        wr_same(32'h0C, 32'h00FF00FF, 4'h5, OKAY);
        rd(32'h0C, 32'hA5FFA5FF, OKAY);
        wr_same(32'h0C, 32'h00000000, 4'h0, OKAY);
        rd(32'h0F, 32'hA5FFA5FF, OKAY);

        // B back-pressure with a second write waiting
        bus.AWADDR = 32'h10; bus.AWVALID = 1'b1;
        bus.WDATA = 32'h11223344; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        tick();
        bus.AWADDR = 32'h14; bus.WDATA = 32'h55667788;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_bvalid",  {31'b0, bus.BVALID},  32'd1);
            check_eq("bp_bresp",   {30'b0, bus.BRESP},   32'd0);
            check_eq("bp_awready", {31'b0, bus.AWREADY}, 32'd0);
            check_eq("bp_wready",  {31'b0, bus.WREADY},  32'd0);
            tick();
        end
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check_eq("bp_bvalid_clr", {31'b0, bus.BVALID},  32'd0);
        check_eq("bp_awready2",   {31'b0, bus.AWREADY}, 32'd1);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        b_done(OKAY);
        rd(32'h10, 32'h11223344, OKAY);
        rd(32'h14, 32'h55667788, OKAY);

        // R back-pressure: data held, ARREADY low
        bus.ARADDR = 32'h10; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        tick();
        bus.ARVALID = 1'b0; bus.ARADDR = 32'h04;
        for (int i = 0; i < 2; i++) begin
            check_eq("rbp_rvalid",  {31'b0, bus.RVALID},  32'd1);
            check_eq("rbp_rdata",   bus.RDATA, 32'h11223344);
            check_eq("rbp_arready", {31'b0, bus.ARREADY}, 32'd0);
            tick();
        end
        bus.RREADY = 1'b1;
        #1;
        check_eq("rbp_arready2", {31'b0, bus.ARREADY}, 32'd1);
        tick();
        bus.RREADY = 1'b0;
        check_eq("rbp_rvalid_clr", {31'b0, bus.RVALID}, 32'd0);

        // Back-to-back reads, one colliding with a write to 0x04
        bus.RREADY = 1'b1; bus.ARADDR = 32'h00; bus.ARVALID = 1'b1;
        tick();
        check_eq("b2b_rvalid0", {31'b0, bus.RVALID}, 32'd1);
        check_eq("b2b_rdata0",  bus.RDATA, 32'h0);
        bus.ARADDR = 32'h04;
        bus.AWADDR = 32'h04; bus.AWVALID = 1'b1;
        bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        #1;
        check_eq("b2b_arready", {31'b0, bus.ARREADY}, 32'd1);
        tick();
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        check_eq("b2b_rvalid1", {31'b0, bus.RVALID}, 32'd1);
        check_eq("b2b_rdata1",  bus.RDATA, 32'hDEADBEEF);
        bus.ARADDR = 32'h08;
        tick();
        bus.ARVALID = 1'b0;
        check_eq("b2b_rvalid2", {31'b0, bus.RVALID}, 32'd1);
        check_eq("b2b_rdata2",  bus.RDATA, 32'h00005678);
        tick();
        bus.RREADY = 1'b0;
        check_eq("b2b_rvalid_clr", {31'b0, bus.RVALID}, 32'd0);
        b_done(OKAY);
        rd(32'h04, 32'hCAFEF00D, OKAY);

        // Reset between AW and W abandons the write
        bus.AWADDR = 32'h18; bus.AWVALID = 1'b1;
        tick();
        bus.AWVALID = 1'b0;
        rst = 1'b1;
        bus.WDATA = 32'h99999999; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
        #1;
        check_eq("mr_wready",  {31'b0, bus.WREADY},  32'd0);
        check_eq("mr_awready", {31'b0, bus.AWREADY}, 32'd0);
        check_eq("mr_arready", {31'b0, bus.ARREADY}, 32'd0);
        tick();
        rst = 1'b0; bus.WVALID = 1'b0;
        #1;
        check_eq("mr_bvalid",   {31'b0, bus.BVALID},  32'd0);
        check_eq("mr_awready2", {31'b0, bus.AWREADY}, 32'd1);
        check_eq("mr_wready2",  {31'b0, bus.WREADY},  32'd1);
        check_eq("mr_arready2", {31'b0, bus.ARREADY}, 32'd1);
        tick();
        check_eq("mr_bvalid2", {31'b0, bus.BVALID}, 32'd0);
        rd(32'h18, 32'h0, OKAY);
        rd(32'h04, 32'h0, OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule : tb_axil_regbank
`default_nettype wire
